// File: rtl/stg_wb.sv
// Writeback stage: GP/SR/AR register files with write-through read ports, retire counter and last PC.
// Optional WB_GP0_ZERO_EN: GP[0] hardwired to zero (writes dropped, reads and bypass return 0).
`ifndef SIZE_ADDR
`define SIZE_ADDR 48
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 24
`endif
`ifndef SIZE_OPC
`define SIZE_OPC 8
`endif
`ifndef SIZE_TGT_GP
`define SIZE_TGT_GP 4
`endif
`ifndef SIZE_TGT_SR
`define SIZE_TGT_SR 2
`endif
`ifndef SIZE_TGT_AR
`define SIZE_TGT_AR 2
`endif
`ifndef OPC_NOP
`define OPC_NOP 8'h00
`endif

module stg_wb #(
  parameter int NUM_GP = 16,
  parameter int NUM_SR = 4,
  parameter int NUM_AR = 4
) (
  input  logic                    iw_clk,
  input  logic                    iw_rst,
  input  logic [`SIZE_ADDR-1:0]   iw_pc,
  input  logic [`SIZE_DATA-1:0]   iw_instr,
  input  logic [`SIZE_OPC-1:0]    iw_opc,
  input  logic [`SIZE_TGT_GP-1:0] iw_tgt_gp,
  input  logic                    iw_tgt_gp_we,
  input  logic [`SIZE_TGT_SR-1:0] iw_tgt_sr,
  input  logic                    iw_tgt_sr_we,
  input  logic [`SIZE_TGT_AR-1:0] iw_tgt_ar,
  input  logic                    iw_tgt_ar_we,
  input  logic [`SIZE_DATA-1:0]   iw_result,
  input  logic [`SIZE_ADDR-1:0]   iw_sr_result,
  input  logic [`SIZE_ADDR-1:0]   iw_ar_result,
  input  logic [`SIZE_TGT_GP-1:0] iw_rd_gp_a,
  input  logic [`SIZE_TGT_GP-1:0] iw_rd_gp_b,
  output logic [`SIZE_DATA-1:0]   ow_rd_gp_a,
  output logic [`SIZE_DATA-1:0]   ow_rd_gp_b,
  input  logic [`SIZE_TGT_SR-1:0] iw_rd_sr,
  output logic [`SIZE_ADDR-1:0]   ow_rd_sr,
  input  logic [`SIZE_TGT_AR-1:0] iw_rd_ar,
  output logic [`SIZE_ADDR-1:0]   ow_rd_ar,
  output logic [`SIZE_ADDR-1:0]   ow_retired,
  output logic [`SIZE_ADDR-1:0]   ow_last_pc
);

  logic [`SIZE_DATA-1:0] gp [NUM_GP];
  logic [`SIZE_ADDR-1:0] sr [NUM_SR];
  logic [`SIZE_ADDR-1:0] ar [NUM_AR];
  logic [`SIZE_ADDR-1:0] retired_q;
  logic [`SIZE_ADDR-1:0] last_pc_q;
  logic                  gp_wr;
  logic                  retire;
  logic                  unused_instr;

  // The instruction word only travels along for trace purposes.
  assign unused_instr = ^iw_instr;

`ifdef WB_GP0_ZERO_EN
  assign gp_wr = iw_tgt_gp_we && (iw_tgt_gp != '0);
`else
  assign gp_wr = iw_tgt_gp_we;
`endif

  assign retire = (iw_opc != `OPC_NOP);

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      for (int i = 0; i < NUM_GP; i++) gp[i] <= '0;
      for (int i = 0; i < NUM_SR; i++) sr[i] <= '0;
      for (int i = 0; i < NUM_AR; i++) ar[i] <= '0;
      retired_q <= '0;
      last_pc_q <= '0;
    end else begin
      if (gp_wr)        gp[iw_tgt_gp] <= iw_result;
      if (iw_tgt_sr_we) sr[iw_tgt_sr] <= iw_sr_result;
      if (iw_tgt_ar_we) ar[iw_tgt_ar] <= iw_ar_result;
      if (retire) begin
        retired_q <= retired_q + 1'b1;
        last_pc_q <= iw_pc;
      end
    end
  end

  // Same-cycle write-through; each file only forwards its own write port.
  always_comb begin
    ow_rd_gp_a = gp[iw_rd_gp_a];
    ow_rd_gp_b = gp[iw_rd_gp_b];
    ow_rd_sr   = sr[iw_rd_sr];
    ow_rd_ar   = ar[iw_rd_ar];
    if (gp_wr && (iw_rd_gp_a == iw_tgt_gp)) ow_rd_gp_a = iw_result;
    if (gp_wr && (iw_rd_gp_b == iw_tgt_gp)) ow_rd_gp_b = iw_result;
    if (iw_tgt_sr_we && (iw_rd_sr == iw_tgt_sr)) ow_rd_sr = iw_sr_result;
    if (iw_tgt_ar_we && (iw_rd_ar == iw_tgt_ar)) ow_rd_ar = iw_ar_result;
`ifdef WB_GP0_ZERO_EN
    if (iw_rd_gp_a == '0) ow_rd_gp_a = '0;
    if (iw_rd_gp_b == '0) ow_rd_gp_b = '0;
`endif
  end

  assign ow_retired = retired_q;
  assign ow_last_pc = last_pc_q;

endmodule

// File: tb/tb_stg_wb.sv
// Bench for stg_wb: randomized traffic checked every cycle against an array-based model, plus pinned literal cases.
`ifndef SIZE_ADDR
`define SIZE_ADDR 48
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 24
`endif
`ifndef SIZE_OPC
`define SIZE_OPC 8
`endif
`ifndef SIZE_TGT_GP
`define SIZE_TGT_GP 4
`endif
`ifndef SIZE_TGT_SR
`define SIZE_TGT_SR 2
`endif
`ifndef SIZE_TGT_AR
`define SIZE_TGT_AR 2
`endif
`ifndef OPC_NOP
`define OPC_NOP 8'h00
`endif

module tb_stg_wb;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [47:0] pc = '0;
  logic [23:0] instr = '0;
  logic [7:0]  opc = `OPC_NOP;
  logic [3:0]  tgt_gp = '0;
  logic        gp_we = 1'b0;
  logic [1:0]  tgt_sr = '0;
  logic        sr_we = 1'b0;
  logic [1:0]  tgt_ar = '0;
  logic        ar_we = 1'b0;
  logic [23:0] result = '0;
  logic [47:0] sr_result = '0;
  logic [47:0] ar_result = '0;
  logic [3:0]  rd_gp_a = '0;
  logic [3:0]  rd_gp_b = '0;
  logic [1:0]  rd_sr = '0;
  logic [1:0]  rd_ar = '0;
  logic [23:0] o_gp_a, o_gp_b;
  logic [47:0] o_sr, o_ar, o_retired, o_last_pc;

  int vectors = 0;
  int errors = 0;
  bit ret_preset = 1'b0;

`ifdef WB_GP0_ZERO_EN
  localparam bit GP0_ZERO = 1'b1;
`else
  localparam bit GP0_ZERO = 1'b0;
`endif

  stg_wb dut (
    .iw_clk(clk), .iw_rst(rst), .iw_pc(pc), .iw_instr(instr), .iw_opc(opc),
    .iw_tgt_gp(tgt_gp), .iw_tgt_gp_we(gp_we), .iw_tgt_sr(tgt_sr), .iw_tgt_sr_we(sr_we),
    .iw_tgt_ar(tgt_ar), .iw_tgt_ar_we(ar_we), .iw_result(result), .iw_sr_result(sr_result),
    .iw_ar_result(ar_result), .iw_rd_gp_a(rd_gp_a), .iw_rd_gp_b(rd_gp_b),
    .ow_rd_gp_a(o_gp_a), .ow_rd_gp_b(o_gp_b), .iw_rd_sr(rd_sr), .ow_rd_sr(o_sr),
    .iw_rd_ar(rd_ar), .ow_rd_ar(o_ar), .ow_retired(o_retired), .ow_last_pc(o_last_pc)
  );

  always #5 clk = ~clk;

  // Reference state: plain arrays updated by the architectural commit rules.
  logic [23:0] m_gp [16];
  logic [47:0] m_sr [4];
  logic [47:0] m_ar [4];
  logic [47:0] m_ret, m_last;

  always @(posedge clk or posedge rst or posedge ret_preset) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) m_gp[i] <= '0;
      for (int i = 0; i < 4; i++) begin m_sr[i] <= '0; m_ar[i] <= '0; end
      m_ret <= '0;
      m_last <= '0;
    end else if (ret_preset) begin
      m_ret <= 48'hFFFF_FFFF_FFFF;
    end else begin
      if (gp_we && !(GP0_ZERO && tgt_gp == 0)) m_gp[tgt_gp] <= result;
      if (sr_we) m_sr[tgt_sr] <= sr_result;
      if (ar_we) m_ar[tgt_ar] <= ar_result;
      if (opc != `OPC_NOP) begin
        m_ret <= m_ret + 48'd1;
        m_last <= pc;
      end
    end
  end

  function automatic logic [23:0] exp_gp(input logic [3:0] idx);
    if (GP0_ZERO && idx == 0) return 24'h0;
    if (gp_we && idx == tgt_gp) return result;
    return m_gp[idx];
  endfunction

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("gp_a", {24'h0, o_gp_a}, {24'h0, exp_gp(rd_gp_a)});
    chk("gp_b", {24'h0, o_gp_b}, {24'h0, exp_gp(rd_gp_b)});
    chk("sr", o_sr, (sr_we && rd_sr == tgt_sr) ? sr_result : m_sr[rd_sr]);
    chk("ar", o_ar, (ar_we && rd_ar == tgt_ar) ? ar_result : m_ar[rd_ar]);
    chk("retired", o_retired, m_ret);
    chk("last_pc", o_last_pc, m_last);
  end

  task automatic idle();
    opc = `OPC_NOP; gp_we = 0; sr_we = 0; ar_we = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic at_neg();
    @(negedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_gp_a"}, {24'h0, o_gp_a}, 48'h0);
    chk({tag, "_gp_b"}, {24'h0, o_gp_b}, 48'h0);
    chk({tag, "_sr"}, o_sr, 48'h0);
    chk({tag, "_ar"}, o_ar, 48'h0);
    chk({tag, "_ret"}, o_retired, 48'h0);
    chk({tag, "_pc"}, o_last_pc, 48'h0);
  endtask

  initial begin
    #3;
    rd_gp_a = 4'd5; rd_gp_b = 4'd9; rd_sr = 2'd1; rd_ar = 2'd3;
    check_all_zero("reset");
    next_cycle();
    rst = 0;

    // Write then read, with bypass in the write cycle.
    next_cycle();
    gp_we = 1; tgt_gp = 4'd5; result = 24'hABCDEF; rd_gp_a = 4'd5;
    at_neg();
    chk("wr_bypass", {24'h0, o_gp_a}, 48'hABCDEF);
    next_cycle();
    idle();
    at_neg();
    chk("wr_after", {24'h0, o_gp_a}, 48'hABCDEF);

    // Dual commit GP + SR.
    next_cycle();
    gp_we = 1; sr_we = 1; tgt_gp = 4'd2; tgt_sr = 2'd1;
    result = 24'h000123; sr_result = 48'h000456_000123; opc = 8'h11; pc = 48'h40;
    next_cycle();
    idle();
    rd_gp_a = 4'd2; rd_sr = 2'd1;
    at_neg();
    chk("dual_gp", {24'h0, o_gp_a}, 48'h000123);
    chk("dual_sr", o_sr, 48'h000456000123);
    chk("dual_ret", o_retired, 48'd1);
    chk("dual_pc", o_last_pc, 48'h40);

    // Bypass on both GP ports and AR.
    next_cycle();
    rd_gp_a = 4'd7; rd_gp_b = 4'd7; gp_we = 1; tgt_gp = 4'd7; result = 24'h55AA55;
    ar_we = 1; tgt_ar = 2'd3; rd_ar = 2'd3; ar_result = 48'h1234_5678_9ABC;
    at_neg();
    chk("byp_a", {24'h0, o_gp_a}, 48'h55AA55);
    chk("byp_b", {24'h0, o_gp_b}, 48'h55AA55);
    chk("byp_ar", o_ar, 48'h1234_5678_9ABC);

    // Retire counter wrap, reached by presetting the counter.
    next_cycle();
    idle();
    #1 force dut.retired_q = 48'hFFFF_FFFF_FFFF;
    ret_preset = 1;
    #1 release dut.retired_q;
    ret_preset = 0;
    at_neg();
    chk("preset", o_retired, 48'hFFFF_FFFF_FFFF);
    next_cycle();
    opc = 8'h22; pc = 48'h1000;
    next_cycle();
    idle(); pc = 48'h2000;
    at_neg();
    chk("wrap_ret", o_retired, 48'h0);
    chk("wrap_pc", o_last_pc, 48'h1000);
    next_cycle();
    at_neg();
    chk("nop_ret", o_retired, 48'h0);
    chk("nop_pc", o_last_pc, 48'h1000);

    // GP0 write.
    next_cycle();
    gp_we = 1; tgt_gp = 4'd0; result = 24'hFFFFFF; rd_gp_a = 4'd0;
    at_neg();
    chk("gp0_wc", {24'h0, o_gp_a}, GP0_ZERO ? 48'h0 : 48'hFFFFFF);
    next_cycle();
    idle();
    at_neg();
    chk("gp0_after", {24'h0, o_gp_a}, GP0_ZERO ? 48'h0 : 48'hFFFFFF);

    // Randomized traffic with occasional asynchronous reset pulses.
    for (int n = 0; n < 3000; n++) begin
      next_cycle();
      if (n % 700 == 699) begin
        idle();
        #2 rst = 1;
        #1;
        check_all_zero("midrst");
        at_neg();
        #1 rst = 0;
        continue;
      end
      opc       = ($urandom_range(0, 9) < 4) ? `OPC_NOP : 8'($urandom_range(1, 255));
      pc        = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
      instr     = 24'($urandom);
      gp_we     = 1'($urandom);
      sr_we     = 1'($urandom);
      ar_we     = 1'($urandom);
      tgt_gp    = 4'($urandom);
      tgt_sr    = 2'($urandom);
      tgt_ar    = 2'($urandom);
      result    = 24'($urandom);
      sr_result = {16'($urandom), 32'($urandom)};
      ar_result = {16'($urandom), 32'($urandom)};
      rd_gp_a   = $urandom_range(0, 1) ? tgt_gp : 4'($urandom);
      rd_gp_b   = $urandom_range(0, 1) ? tgt_gp : 4'($urandom);
      rd_sr     = $urandom_range(0, 1) ? tgt_sr : 2'($urandom);
      rd_ar     = $urandom_range(0, 1) ? tgt_ar : 2'($urandom);
    end
    next_cycle();
    idle();
    at_neg();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
